regfile_access_ctrl: RTL and testbench

//   Initiator side of the register file interface for the multi-cycle RV32I core.

---
 rtl/regfile_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register file access controller for the multi-cycle RV32I core.
// Accepts one decoded instruction, reads its operands, hands them to execute,
// then commits the execute result with a single-cycle register file write.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for decode; dec_ready=1
// READ    | read addresses driven; operands captured on the clock edge
// ISSUE   | op_valid=1; operands held until execute takes them
// WAIT_WB | wb_ready=1; waiting for the execute result
// WRITE   | rf_we pulse (suppressed for rd==0); instruction retires
module regfile_access_ctrl #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [AW-1:0]    dec_rs1,
  input  logic [AW-1:0]    dec_rs2,
  input  logic [AW-1:0]    dec_rd,
  input  logic             dec_wb_en,
  output logic [AW-1:0]    rf_rs1_addr,
  output logic [AW-1:0]    rf_rs2_addr,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  output logic             rf_we,
  output logic [AW-1:0]    rf_rd_addr,
  output logic [XLEN-1:0]  rf_rd_data,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [XLEN-1:0]  op_rs1_data,
  output logic [XLEN-1:0]  op_rs2_data,
  output logic [AW-1:0]    op_rd,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [XLEN-1:0]  wb_data,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    ISSUE   = 3'd2,
    WAIT_WB = 3'd3,
    WRITE   = 3'd4
  } state_t;

  state_t state, next_state;

  logic [AW-1:0]    rs1_q, rs2_q, rd_q;
  logic             wb_en_q;
  logic [XLEN-1:0]  rs1_data_q, rs2_data_q, wb_data_q;
  logic [CNT_W-1:0] retired_q;

  logic latch_dec, capture_ops, latch_wb, retire;

  // Next-state and handshake/strobe decode; every output defaulted first.
  always_comb begin
    next_state  = state;
    dec_ready   = 1'b0;
    op_valid    = 1'b0;
    wb_ready    = 1'b0;
    rf_we       = 1'b0;
    latch_dec   = 1'b0;
    capture_ops = 1'b0;
    latch_wb    = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        dec_ready = 1'b1;
        if (dec_valid) begin
          latch_dec  = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        capture_ops = 1'b1;
        next_state  = ISSUE;
      end
      ISSUE: begin
        op_valid = 1'b1;
        if (op_ready) begin
          if (wb_en_q) begin
            next_state = WAIT_WB;
          end else begin
            retire     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      WAIT_WB: begin
        wb_ready = 1'b1;
        if (wb_valid) begin
          latch_wb   = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        // x0 is hardwired; the result is consumed but never written.
        rf_we      = (rd_q != '0) && !reset;
        retire     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Latched instruction fields, operands, writeback value and retire count.
  always_ff @(posedge clock) begin
    if (reset) begin
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      wb_en_q    <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      wb_data_q  <= '0;
      retired_q  <= '0;
    end else begin
      if (latch_dec) begin
        rs1_q   <= dec_rs1;
        rs2_q   <= dec_rs2;
        rd_q    <= dec_rd;
        wb_en_q <= dec_wb_en;
      end
      if (capture_ops) begin
        rs1_data_q <= rf_rs1_data;
        rs2_data_q <= rf_rs2_data;
      end
      if (latch_wb) wb_data_q <= wb_data;
      if (retire)   retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign rf_rs1_addr = rs1_q;
  assign rf_rs2_addr = rs2_q;
  assign rf_rd_addr  = rd_q;
  assign rf_rd_data  = wb_data_q;
  assign op_rs1_data = rs1_data_q;
  assign op_rs2_data = rs2_data_q;
  assign op_rd       = rd_q;
  assign busy        = (state != IDLE);
  assign retired     = retired_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a small behavioural register file.
module tb_regfile_access_ctrl;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 4;

  logic             clock;
  logic             reset;
  logic             dec_valid;
  logic             dec_ready;
  logic [AW-1:0]    dec_rs1, dec_rs2, dec_rd;
  logic             dec_wb_en;
  logic [AW-1:0]    rf_rs1_addr, rf_rs2_addr;
  logic [XLEN-1:0]  rf_rs1_data, rf_rs2_data;
  logic             rf_we;
  logic [AW-1:0]    rf_rd_addr;
  logic [XLEN-1:0]  rf_rd_data;
  logic             op_valid;
  logic             op_ready;
  logic [XLEN-1:0]  op_rs1_data, op_rs2_data;
  logic [AW-1:0]    op_rd;
  logic             wb_valid;
  logic             wb_ready;
  logic [XLEN-1:0]  wb_data;
  logic             busy;
  logic [CNT_W-1:0] retired;

  int errors = 0;
  int checks = 0;
  logic preload;

  logic [XLEN-1:0] rf [32];

  regfile_access_ctrl #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_wb_en(dec_wb_en),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data), .op_rd(op_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .busy(busy), .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural register file: async read, write on rf_we.
  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : 32'd0;
    end else if (rf_we) begin
      rf[rf_rd_addr] <= rf_rd_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue_dec(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic [AW-1:0] rd, input logic wb_en);
    dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_wb_en = wb_en;
    tick();
    dec_valid = 1'b0;
  endtask

  // Quick no-writeback instruction: handshake, READ, ISSUE accepted at once.
  task automatic run_nowb();
    issue_dec(5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_wb_en = 1'b0;
    op_ready = 1'b0; wb_valid = 1'b0; wb_data = '0;
    tick(); tick();
    reset = 1'b0; preload = 1'b0;
    #1;

    // Reset state
    check("rst_dec_ready", 32'(dec_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_op_valid",  32'(op_valid),  32'd0);
    check("rst_wb_ready",  32'(wb_ready),  32'd0);
    check("rst_rf_we",     32'(rf_we),     32'd0);
    check("rst_retired",   32'(retired),   32'd0);
    check("rst_op_rs1",    op_rs1_data,    32'd0);
    check("rst_rd_addr",   32'(rf_rd_addr), 32'd0);

    // 1: x3 = x1 + x2 style instruction, writeback 12
    issue_dec(5'd1, 5'd2, 5'd3, 1'b1);
    check("t1_read_busy",  32'(busy),        32'd1);
    check("t1_read_dready",32'(dec_ready),   32'd0);
    check("t1_read_opv",   32'(op_valid),    32'd0);
    check("t1_rs1_addr",   32'(rf_rs1_addr), 32'd1);
    check("t1_rs2_addr",   32'(rf_rs2_addr), 32'd2);
    tick();
    check("t1_op_valid",   32'(op_valid), 32'd1);
    check("t1_op_rs1",     op_rs1_data,   32'd5);
    check("t1_op_rs2",     op_rs2_data,   32'd7);
    check("t1_op_rd",      32'(op_rd),    32'd3);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("t1_wb_ready",   32'(wb_ready), 32'd1);
    check("t1_opv_low",    32'(op_valid), 32'd0);
    wb_valid = 1'b1; wb_data = 32'd12;
    tick();
    wb_valid = 1'b0;
    check("t1_rf_we",      32'(rf_we),      32'd1);
    check("t1_rd_addr",    32'(rf_rd_addr), 32'd3);
    check("t1_rd_data",    rf_rd_data,      32'd12);
    tick();
    check("t1_rf_we_off",  32'(rf_we),   32'd0);
    check("t1_retired",    32'(retired), 32'd1);
    check("t1_x3",         rf[3],        32'd12);

    // 2: no writeback, execute stalls 4 cycles; stray wb_valid ignored
    issue_dec(5'd3, 5'd1, 5'd5, 1'b0);
    tick();
    wb_valid = 1'b1; wb_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      check("t2_op_valid", 32'(op_valid), 32'd1);
      check("t2_op_rs1",   op_rs1_data,   32'd12);
      check("t2_op_rs2",   op_rs2_data,   32'd5);
      check("t2_wb_ready", 32'(wb_ready), 32'd0);
      if (i < 3) tick();
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0; wb_valid = 1'b0;
    check("t2_idle",       32'(busy),     32'd0);
    check("t2_wb_ready",   32'(wb_ready), 32'd0);
    check("t2_retired",    32'(retired),  32'd2);

    // 3: rd=0 with writeback: consumed but never written
    issue_dec(5'd1, 5'd2, 5'd0, 1'b1);
    tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("t3_wb_ready",   32'(wb_ready), 32'd1);
    wb_valid = 1'b1; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_valid = 1'b0;
    check("t3_rf_we",      32'(rf_we),    32'd0);
    check("t3_rd_data",    rf_rd_data,    32'hDEAD_BEEF);
    check("t3_busy",       32'(busy),     32'd1);
    tick();
    check("t3_retired",    32'(retired),  32'd3);
    check("t3_x0",         rf[0],         32'd0);

    // 4a: reset while waiting for writeback
    issue_dec(5'd1, 5'd2, 5'd6, 1'b1);
    tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("t4a_wb_ready",  32'(wb_ready), 32'd1);
    reset = 1'b1;
    #1;
    check("t4a_rf_we",     32'(rf_we), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("t4a_idle",      32'(busy),      32'd0);
    check("t4a_dready",    32'(dec_ready), 32'd1);
    check("t4a_retired",   32'(retired),   32'd0);
    check("t4a_op_rs1",    op_rs1_data,    32'd0);

    // 4b: reset in the write cycle: the write is suppressed
    issue_dec(5'd1, 5'd2, 5'd6, 1'b1);
    tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    wb_valid = 1'b1; wb_data = 32'h55;
    tick();
    wb_valid = 1'b0;
    check("t4b_in_write",  32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t4b_rf_we",     32'(rf_we), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("t4b_idle",      32'(busy),       32'd0);
    check("t4b_rf_we_off", 32'(rf_we),      32'd0);
    check("t4b_retired",   32'(retired),    32'd0);
    check("t4b_x6",        rf[6],           32'd0);
    check("t4b_rd_addr",   32'(rf_rd_addr), 32'd0);

    // 5: A writes x4=9, B reads x4; B held on dec during A is ignored
    issue_dec(5'd0, 5'd0, 5'd4, 1'b1);
    dec_valid = 1'b1; dec_rs1 = 5'd4; dec_rs2 = 5'd3; dec_rd = 5'd8; dec_wb_en = 1'b0;
    check("t5_dready_busy", 32'(dec_ready),   32'd0);
    check("t5_rs1_addr_A",  32'(rf_rs1_addr), 32'd0);
    tick();
    check("t5_op_rd_A",     32'(op_rd),       32'd4);
    check("t5_op_rs1_A",    op_rs1_data,      32'd0);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    wb_valid = 1'b1; wb_data = 32'd9;
    tick();
    wb_valid = 1'b0;
    check("t5_rd_addr_A",   32'(rf_rd_addr),  32'd4);
    check("t5_rf_we_A",     32'(rf_we),       32'd1);
    tick();
    check("t5_dready_idle", 32'(dec_ready),   32'd1);
    check("t5_retired_A",   32'(retired),     32'd1);
    tick();
    dec_valid = 1'b0;
    check("t5_rs1_addr_B",  32'(rf_rs1_addr), 32'd4);
    tick();
    check("t5_op_rs1_B",    op_rs1_data,      32'd9);
    check("t5_op_rs2_B",    op_rs2_data,      32'd12);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("t5_retired_B",   32'(retired),     32'd2);

    // 6: 4-bit retire counter wraps 15 -> 0
    for (int i = 0; i < 13; i++) run_nowb();
    check("t6_retired_max", 32'(retired), 32'd15);
    run_nowb();
    check("t6_retired_wrap", 32'(retired), 32'd0);
    check("t6_idle",         32'(busy),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
